// File: rtl/strided_addr_gen.sv
// Strided burst address generator for the decoder message/LLR RAMs.
// Emits len addresses from base, stepping +/-stride modulo limit, with valid/ready backpressure.
module strided_addr_gen #(
  parameter int WIDTH = 10,
  parameter int LEN_W = 10,
  parameter logic [WIDTH-1:0] PRESET = {WIDTH{1'b1}} - 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] stride,
  input  logic [WIDTH-1:0] limit,
  input  logic [LEN_W-1:0] len,
  input  logic             dir,
  input  logic             preset,
  input  logic             hold,
  input  logic             addr_ready,
  output logic [WIDTH-1:0] addr,
  output logic             addr_valid,
  output logic             addr_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] stride;
    logic [WIDTH-1:0] limit;
    logic [LEN_W-1:0] len;
    logic             dir;
  } cfg_t;

  state_t           state, state_nxt;
  cfg_t             cfg, cfg_nxt;
  logic [WIDTH-1:0] addr_nxt, step_addr;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             done_nxt;
  logic             accept, is_last;
  logic [WIDTH:0]   sum, sum_wrap;

  assign busy       = (state == RUN);
  assign addr_valid = busy & ~hold;
  assign is_last    = (cnt == cfg.len - 1'b1);
  assign addr_last  = addr_valid & is_last;
  assign accept     = addr_valid & addr_ready;

  // Next address in the burst, modulo limit (limit == 0 means natural wrap).
  always_comb begin
    sum      = {1'b0, addr} + {1'b0, cfg.stride};
    sum_wrap = sum - {1'b0, cfg.limit};
    if (!cfg.dir) begin
      if (cfg.limit != '0 && sum >= {1'b0, cfg.limit}) step_addr = sum_wrap[WIDTH-1:0];
      else                                             step_addr = sum[WIDTH-1:0];
    end else if (addr >= cfg.stride) begin
      step_addr = addr - cfg.stride;
    end else begin
      // With limit == 0 this reduces to addr - stride, i.e. the 2^WIDTH wrap.
      step_addr = addr + cfg.limit - cfg.stride;
    end
  end

  always_comb begin
    state_nxt = state;
    cfg_nxt   = cfg;
    addr_nxt  = addr;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cfg_nxt.stride = stride;
          cfg_nxt.limit  = limit;
          cfg_nxt.len    = len;
          cfg_nxt.dir    = dir;
          if (len != '0) begin
            state_nxt = RUN;
            addr_nxt  = base;
            cnt_nxt   = '0;
          end else begin
            done_nxt  = 1'b1;
          end
        end else if (preset) begin
          addr_nxt = PRESET;
        end
      end
      RUN: begin
        if (accept) begin
          if (is_last) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            addr_nxt = step_addr;
            cnt_nxt  = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cfg   <= '0;
      addr  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cfg   <= cfg_nxt;
      addr  <= addr_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: doc/strided_addr_gen.md
# strided_addr_gen

Parametrised strided address generator for the NB-LDPC decoder memories. It emits a burst of `len` addresses starting at `base` and stepping by a runtime `stride`, up or down. Addresses wrap modulo a runtime `limit`, and a valid/ready handshake provides backpressure. It sits between the layer scheduler, which issues `start`, and the message/LLR RAM read/write ports. It also keeps a preset load used by the scheduler's pre-fetch phase.

## Interface
- `WIDTH`, 10, address width in bits.
- `LEN_W`, 10, width of the burst-length field.
- `PRESET`, `{WIDTH{1'b1}} - 1` (10'h3FE at default), value loaded by `preset`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request a burst; sampled only in IDLE.
- `base`  in  WIDTH  first address.
- `stride`  in  WIDTH  step size.
- `limit`  in  WIDTH  wrap modulus; 0 means natural 2^WIDTH wrap.
- `len`  in  LEN_W  number of addresses in the burst.
- `dir`  in  1  0 = increment, 1 = decrement.
- `preset`  in  1  in IDLE, load `addr` with `PRESET`.
- `hold`  in  1  freeze the burst; no handshake while high.
- `addr_ready`  in  1  consumer accepts the current address.
- `addr`  out  WIDTH  current address, registered.
- `addr_valid`  out  1  `addr` is a burst beat.
- `addr_last`  out  1  the current beat is the final one.
- `busy`  out  1  state is RUN.
- `done`  out  1  one-cycle pulse after the burst ends.

## Operation
- Reset (asynchronous) forces state IDLE and clears `addr`, `addr_valid`, `addr_last`, `busy`, `done` to 0.
- `base`, `stride`, `limit`, `len`, `dir` are captured at start acceptance. Later changes have no effect until the next burst.
- State IDLE:
  - `start` with `len`≠0: go to RUN, `addr`←`base`, beat counter←0.
  - `start` with `len`=0: stay IDLE, pulse `done` next cycle, never assert `addr_valid`.
  - `preset` (no `start`): `addr`←`PRESET`.
  - If `start` and `preset` are both high, `start` wins.
  - Otherwise `addr` holds its value.
- State RUN: `addr_valid` = ~`hold`. A beat is accepted on `addr_valid` & `addr_ready`.
  - On an accepted non-last beat: `addr` advances and the counter increments.
  - On the accepted last beat (counter = len−1): go to IDLE, `done`=1 for one cycle, `addr` holds the last address.
- `addr_last` is high whenever `addr_valid` is high and counter = len−1.
- `start` and `preset` are ignored while `busy`=1.
- Increment arithmetic:
  - Compute s = `addr` + `stride` in WIDTH+1 bits.
  - If `limit`≠0 and s ≥ `limit`, next = s − `limit`; otherwise next = s[WIDTH−1:0].
- Decrement arithmetic:
  - If `addr` ≥ `stride`, next = `addr` − `stride`.
  - Otherwise, with `limit`≠0, next = `addr` + `limit` − `stride`; with `limit`=0, next = 2^WIDTH wrap.
- Legal configurations require `base` < `limit` and `stride` ≤ `limit` when `limit`≠0. Other settings produce undefined addresses but must not hang the FSM; the counter still terminates after `len` beats.

## Timing
- `start` sampled high at edge N gives `busy`=1, `addr_valid`=1 (with `hold`=0) and `addr`=`base` after edge N.
- Throughput is one address per cycle while `addr_ready`=1 and `hold`=0.
- Backpressure: with `addr_ready`=0, `addr` and `addr_last` stay stable and `addr_valid` stays high.
- `hold` deasserts `addr_valid` combinationally from the registered state. Address and counter are frozen.
- The last accept at edge M gives `busy`=0, `addr_valid`=0, `done`=1 after edge M. `done` drops after M+1.
- A new `start` in the `done` cycle is accepted, so bursts run back to back with one idle cycle.
- `preset` takes effect at the next edge: `addr`=`PRESET`.
- Reset asserted mid-burst clears everything immediately. After release the block waits in IDLE and no `done` is produced.

## Test plan
- Up, no wrap: `base`=0, `stride`=2, `limit`=0, `len`=4, `addr_ready`=1 → addr 0,2,4,6 on consecutive cycles; `addr_last` with 6; `done` one cycle later.
- Wrap up: `base`=6, `stride`=3, `limit`=10, `len`=4 → 6,9,2,5. Natural wrap: `base`=1020, `stride`=2, `limit`=0, `len`=3 → 1020,1022,0.
- Down with wrap: `dir`=1, `base`=1, `stride`=2, `limit`=10, `len`=3 → 1,9,7; `done` pulses once.
- Backpressure and hold: during the previous burst, drop `addr_ready` for 3 cycles at addr 9, then raise `hold` for 2 cycles → addr stays 9, `addr_valid` low only during `hold`, sequence resumes 9,7 unchanged.
- Edge controls:
  - `len`=0 start → `done` next cycle, `addr_valid` never high.
  - `preset` in IDLE → `addr`=10'h3FE.
  - `start` while `busy` → ignored.
- Reset mid-burst at beat 2 of a `len`=8 burst → all outputs 0 immediately, no `done`. A fresh burst afterwards starts at `base`.
